// File: rtl/riscv_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_unit_if
// Description : Instruction-memory request/response bus between the fetch
//               unit (master) and instruction memory (slave). Single
//               outstanding request, address held until ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            o_fetch_imem_req;
    logic [XLEN-1:0] o_fetch_imem_addr;
    logic            i_fetch_imem_ack;
    logic [XLEN-1:0] i_fetch_imem_rdata;

    modport master (
        output o_fetch_imem_req,
        output o_fetch_imem_addr,
        input  i_fetch_imem_ack,
        input  i_fetch_imem_rdata
    );

    modport slave (
        input  o_fetch_imem_req,
        input  o_fetch_imem_addr,
        output i_fetch_imem_ack,
        output i_fetch_imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_unit
// Description : RV32I instruction-fetch stage. Owns the PC, issues one
//               outstanding request at a time, presents {instr, pc, pcplus4}
//               to the fetch/decode register, honours stalls and redirects,
//               and drives a NOP bubble when nothing valid is available.
//               Optional feature macro: RISCV_FETCH_MISALIGN_EN (misaligned
//               redirect trap state instead of forcing target alignment).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    riscv_fetch_unit_if.master   imem,
    input  wire logic            i_fetch_stall,
    input  wire logic            i_fetch_redirect,
    input  wire logic [XLEN-1:0] i_fetch_redirect_pc,
    output logic                 o_fetch_valid,
    output logic [XLEN-1:0]      o_fetch_instr,
    output logic [XLEN-1:0]      o_fetch_pc,
    output logic [XLEN-1:0]      o_fetch_pcplus4,
    output logic                 o_fetch_misaligned
);

    localparam logic [XLEN-1:0] c_step       = XLEN'(4);
    localparam logic [XLEN-1:0] c_align_mask = XLEN'(3);

`ifdef RISCV_FETCH_MISALIGN_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
`endif

    state_t          r_state;
    logic [XLEN-1:0] r_pc;          // next PC to fetch / PC being presented
    logic [XLEN-1:0] r_addr;        // address of the outstanding request
    logic [XLEN-1:0] r_hold_instr;  // instruction parked while stalled

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_drain_pc;
    state_t          w_target_state;
    state_t          w_drain_state;
    logic            w_fetch_hit;
    logic            w_hold_out;

    assign w_pc_plus4 = r_pc + c_step;

    // When the pending drain ack lands, a same-cycle redirect supersedes r_pc.
    assign w_drain_pc = i_fetch_redirect ? w_target : r_pc;

`ifdef RISCV_FETCH_MISALIGN_EN
    assign w_target       = i_fetch_redirect_pc;
    assign w_target_state = (w_target[1:0] != 2'b00) ? S_ERR : S_FETCH;
    assign w_drain_state  = (w_drain_pc[1:0] != 2'b00) ? S_ERR : S_FETCH;
`else
    // Without the trap, a misaligned target is silently word-aligned.
    assign w_target       = i_fetch_redirect_pc & ~c_align_mask;
    assign w_target_state = S_FETCH;
    assign w_drain_state  = S_FETCH;
`endif

    // FSM: PC, request address, held instruction and state advance together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_fetch_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_state <= w_target_state;
                    end else begin
                        r_addr  <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_fetch_redirect) begin
                        r_pc <= w_target;
                        if (imem.i_fetch_imem_ack) begin
                            // Returned word belongs to the squashed path.
                            r_addr  <= w_target;
                            r_state <= w_target_state;
                        end else begin
                            // Request in flight: keep r_addr until it completes.
                            r_state <= S_DRAIN;
                        end
                    end else if (imem.i_fetch_imem_ack) begin
                        if (i_fetch_stall) begin
                            r_hold_instr <= imem.i_fetch_imem_rdata;
                            r_state      <= S_HOLD;
                        end else begin
                            r_pc   <= w_pc_plus4;
                            r_addr <= w_pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_fetch_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_state <= w_target_state;
                    end else if (!i_fetch_stall) begin
                        r_pc    <= w_pc_plus4;
                        r_addr  <= w_pc_plus4;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (i_fetch_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem.i_fetch_imem_ack) begin
                        r_addr  <= w_drain_pc;
                        r_state <= w_drain_state;
                    end
                end
`ifdef RISCV_FETCH_MISALIGN_EN
                S_ERR: begin
                    if (i_fetch_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_state <= w_target_state;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request is a pure decode of the state register, so reset drops it at once.
    assign imem.o_fetch_imem_req  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem.o_fetch_imem_addr = r_addr;

    // Zero-latency path: an acked word is presented in the same cycle.
    assign w_fetch_hit = (r_state == S_FETCH) && imem.i_fetch_imem_ack && !i_fetch_redirect;
    assign w_hold_out  = (r_state == S_HOLD) && !i_fetch_redirect;

    assign o_fetch_valid   = w_fetch_hit || w_hold_out;
    assign o_fetch_instr   = w_fetch_hit ? imem.i_fetch_imem_rdata :
                             w_hold_out  ? r_hold_instr : NOP_INSTR;
    assign o_fetch_pc      = r_pc;
    assign o_fetch_pcplus4 = w_pc_plus4;

`ifdef RISCV_FETCH_MISALIGN_EN
    assign o_fetch_misaligned = (r_state == S_ERR);
`else
    assign o_fetch_misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_fetch_unit
// Description : Self-checking bench for riscv_fetch_unit: directed vector
//               table, hand-written corner sequences (misaligned redirect,
//               asynchronous reset mid-request) and a randomized run against
//               a transaction-level reference model. Honours
//               RISCV_FETCH_MISALIGN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        mis;

    int n_vec;
    int n_err;

    riscv_fetch_unit_if #(.XLEN(32)) imem_if ();

    riscv_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .imem                (imem_if),
        .i_fetch_stall       (stall),
        .i_fetch_redirect    (redir),
        .i_fetch_redirect_pc (redir_pc),
        .o_fetch_valid       (valid),
        .o_fetch_instr       (instr),
        .o_fetch_pc          (pc),
        .o_fetch_pcplus4     (pcplus4),
        .o_fetch_misaligned  (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a word that is distinguishable from its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    typedef struct packed {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_pc, input logic e_mis);
        chk({tag, " req"}, {31'd0, imem_if.o_fetch_imem_req}, {31'd0, e_req});
        if (e_req) chk({tag, " addr"}, imem_if.o_fetch_imem_addr, e_addr);
        chk({tag, " valid"}, {31'd0, valid}, {31'd0, e_valid});
        chk({tag, " instr"}, instr, e_instr);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " pcplus4"}, pcplus4, e_pc + 32'd4);
        chk({tag, " misaligned"}, {31'd0, mis}, {31'd0, e_mis});
    endtask

    task automatic apply(input logic a, input logic s, input logic r,
                         input logic [31:0] t, input logic [31:0] d);
        imem_if.i_fetch_imem_ack   = a;
        imem_if.i_fetch_imem_rdata = d;
        stall    = s;
        redir    = r;
        redir_pc = t;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        imem_if.i_fetch_imem_ack   = 1'b0;
        imem_if.i_fetch_imem_rdata = 32'h0;
        stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        @(negedge clk);
        check_outputs(tag, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        advance();
        rst = 1'b0;
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks: whether the first request has started, the PC, the single
    // outstanding request (address, and whether its data is to be thrown
    // away), a parked instruction, and the trap condition.
    logic        m_started, m_req, m_discard, m_held, m_err;
    logic [31:0] m_pc, m_req_addr, m_held_word;

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef RISCV_FETCH_MISALIGN_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_req = 1'b0; m_discard = 1'b0;
        m_held = 1'b0; m_err = 1'b0;
        m_pc = 32'h0; m_req_addr = 32'h0; m_held_word = NOP;
    endtask

    task automatic model_start(input logic [31:0] a);
        m_req_addr = a;
        m_err      = (a[1:0] != 2'b00);
        m_req      = !m_err;
    endtask

    task automatic model_step(input logic a, input logic s, input logic r, input logic [31:0] tgt);
        logic [31:0] t;
        t = eff_target(tgt);
        if (!m_started) begin
            m_started = 1'b1;
            if (r) m_pc = t;
            model_start(m_pc);
        end else if (m_err) begin
            if (r) begin m_pc = t; model_start(t); end
        end else if (m_held) begin
            if (r) begin
                m_held = 1'b0; m_pc = t; model_start(t);
            end else if (!s) begin
                m_held = 1'b0; m_pc = m_pc + 32'd4; model_start(m_pc);
            end
        end else if (m_req && m_discard) begin
            if (r) m_pc = t;
            if (a) begin m_discard = 1'b0; model_start(m_pc); end
        end else if (m_req) begin
            if (r) begin
                m_pc = t;
                if (a) model_start(t);
                else   m_discard = 1'b1;
            end else if (a) begin
                if (s) begin
                    m_held = 1'b1; m_held_word = mem_word(m_req_addr); m_req = 1'b0;
                end else begin
                    m_pc = m_pc + 32'd4; model_start(m_pc);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        logic        ra, rs, rr, e_valid;
        logic [31:0] rt, rd, e_instr;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;

        //               ack   stl   rdr   tgt           rdata                    req   addr          vld   instr                    pc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,                   1'b0, 32'h0,        1'b0, NOP,                     32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'h0),         1'b1, 32'h0,        1'b1, mem_word(32'h0),         32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'h4),         1'b1, 32'h4,        1'b1, mem_word(32'h4),         32'h4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        mem_word(32'h8),         1'b1, 32'h8,        1'b1, mem_word(32'h8),         32'h8};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,                   1'b0, 32'h0,        1'b1, mem_word(32'h8),         32'h8};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,                   1'b0, 32'h0,        1'b1, mem_word(32'h8),         32'h8};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,                   1'b0, 32'h0,        1'b1, mem_word(32'h8),         32'h8};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'hC),         1'b1, 32'hC,        1'b1, mem_word(32'hC),         32'hC};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h100,      32'h0,                   1'b1, 32'h10,       1'b0, NOP,                     32'h10};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,                   1'b1, 32'h10,       1'b0, NOP,                     32'h100};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'h10),        1'b1, 32'h10,       1'b0, NOP,                     32'h100};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        mem_word(32'h100),       1'b1, 32'h100,      1'b1, mem_word(32'h100),       32'h100};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h40,       32'h0,                   1'b0, 32'h0,        1'b0, NOP,                     32'h100};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'h40),        1'b1, 32'h40,       1'b1, mem_word(32'h40),        32'h40};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, mem_word(32'h44),       1'b1, 32'h44,       1'b0, NOP,                     32'h44};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'hFFFF_FFFC), 1'b1, 32'hFFFF_FFFC, 1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        mem_word(32'h0),         1'b1, 32'h0,        1'b1, mem_word(32'h0),         32'h0};

        do_reset("reset");

        // Directed table: start-up, stall, drain, redirect in HOLD, wrap.
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].ack, tbl[i].stall, tbl[i].redir, tbl[i].tgt, tbl[i].rdata);
            check_outputs($sformatf("tbl[%0d]", i), tbl[i].e_req, tbl[i].e_addr,
                          tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc, 1'b0);
            advance();
        end

        // Misaligned redirect while fetching at 0x4.
        apply(1'b1, 1'b0, 1'b1, 32'h102, mem_word(32'h4));
        check_outputs("mis redirect", 1'b1, 32'h4, 1'b0, NOP, 32'h4, 1'b0);
        advance();
`ifdef RISCV_FETCH_MISALIGN_EN
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_outputs("mis err1", 1'b0, 32'h0, 1'b0, NOP, 32'h102, 1'b1);
        advance();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
        check_outputs("mis err stray ack", 1'b0, 32'h0, 1'b0, NOP, 32'h102, 1'b1);
        advance();
        apply(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
        check_outputs("mis exit", 1'b0, 32'h0, 1'b0, NOP, 32'h102, 1'b1);
        advance();
        apply(1'b1, 1'b0, 1'b0, 32'h0, mem_word(32'h200));
        check_outputs("mis refetch", 1'b1, 32'h200, 1'b1, mem_word(32'h200), 32'h200, 1'b0);
        advance();
`else
        apply(1'b1, 1'b0, 1'b0, 32'h0, mem_word(32'h100));
        check_outputs("mis aligned fetch", 1'b1, 32'h100, 1'b1, mem_word(32'h100), 32'h100, 1'b0);
        advance();
`endif

        // Asynchronous reset mid-request: req must fall before any clock edge.
        imem_if.i_fetch_imem_ack = 1'b0;
        stall = 1'b0; redir = 1'b0;
        #1;
        chk("pre-reset req", {31'd0, imem_if.o_fetch_imem_req}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_outputs("async reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        advance();
        rst = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        check_outputs("idle ignores ack", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        advance();
        apply(1'b1, 1'b0, 1'b0, 32'h0, mem_word(32'h0));
        check_outputs("first fetch after reset", 1'b1, 32'h0, 1'b1, mem_word(32'h0), 32'h0, 1'b0);
        advance();

        // Randomized run against the reference model.
        do_reset("random reset");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int sel;
            rs = ($urandom % 4) == 0;
            rr = ($urandom % 10) == 0;
            sel = int'($urandom % 8);
            rt = 32'($urandom_range(0, 255)) << 2;
            if (sel == 0)      rt = rt | 32'($urandom_range(1, 3));
            else if (sel == 1) rt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            if (m_req) ra = ($urandom % 3) != 0;
            else       ra = ($urandom % 16) == 0;
            rd = (m_req && ra) ? mem_word(m_req_addr) : $urandom;

            e_valid = !rr && ((m_req && !m_discard && ra) || m_held);
            e_instr = !e_valid ? NOP : (m_held ? m_held_word : mem_word(m_req_addr));

            apply(ra, rs, rr, rt, rd);
            check_outputs($sformatf("rnd[%0d]", c), m_req, m_req_addr, e_valid, e_instr, m_pc, m_err);
            model_step(ra, rs, rr, rt);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter, issues single-outstanding requests to instruction memory, and presents `{instr, pc, pcplus4}` to the fetch/decode pipeline register. It honours stalls from the hazard unit and PC redirects from execute, and never loses or duplicates an instruction. When no valid instruction is available it drives a NOP bubble.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `NOP_INSTR`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`).
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `o_fetch_imem_req` output 1: memory request; held until ack.
- `o_fetch_imem_addr` output `XLEN`: request address; stable while req=1 and no ack.
- `i_fetch_imem_ack` input 1: read data valid this cycle. Same-cycle ack is allowed.
- `i_fetch_imem_rdata` input `XLEN`: instruction word, sampled only when ack=1.
- `i_fetch_stall` input 1: downstream register is not loading this cycle.
- `i_fetch_redirect` input 1: taken branch or jump.
- `i_fetch_redirect_pc` input `XLEN`: redirect target.
- `o_fetch_valid` output 1: the outputs below carry a real instruction.
- `o_fetch_instr` output `XLEN`: instruction, or `NOP_INSTR` when not valid.
- `o_fetch_pc` output `XLEN`: PC of `o_fetch_instr`.
- `o_fetch_pcplus4` output `XLEN`: `o_fetch_pc + 4`, wrapping modulo 2^32.
- `o_fetch_misaligned` output 1: misaligned redirect trap (see Configuration).

## Operation
**State registers**
- `r_pc`: next PC to fetch.
- `r_addr`: address of the outstanding request.
- `r_hold_instr`: buffered instruction.
- FSM states: IDLE, FETCH, HOLD, DRAIN, and ERR (ERR exists only when the macro is defined).

**IDLE**
- Entered on reset. req=0, valid=0.
- Moves to FETCH on the next clock. A redirect in this cycle loads `r_pc`.

**FETCH**
- req=1, addr=`r_addr` (equal to `r_pc`).
- ack=1 and no redirect: valid=1, instr=rdata.
  - If stall=0: `r_pc`/`r_addr` <= pc+4, stay in FETCH.
  - If stall=1: `r_hold_instr` <= rdata, go to HOLD.
- ack=0 and no redirect: valid=0, stay in FETCH.
- redirect with ack=1: discard the data, valid=0, `r_pc`/`r_addr` <= target, stay in FETCH.
- redirect with ack=0: `r_pc` <= target, go to DRAIN. `r_addr` keeps the old address.

**HOLD**
- req=0, valid=1, instr=`r_hold_instr`.
- stall=0: pc+4 is loaded, go to FETCH.
- redirect (overrides stall): load target, go to FETCH.

**DRAIN**
- req=1 at the old `r_addr`, valid=0.
- On ack: discard the data, `r_addr` <= `r_pc`, go to FETCH.
- A further redirect here only overwrites `r_pc`.

**Priority and outputs**
- Priority order: reset > redirect > stall > ack.
- `o_fetch_pc`/`o_fetch_pcplus4` reflect the instruction being presented. When valid=0 they hold the current `r_pc`/`r_pc+4`.
- The hazard unit must drive the FD register enable as `!i_fetch_stall` and its clear from the redirect.

## Timing
**Reset values**
- state=IDLE, `r_pc`=`r_addr`=`RESET_PC`, `r_hold_instr`=`NOP_INSTR`.
- req=0, valid=0, instr=`NOP_INSTR`, pc=`RESET_PC`, pcplus4=`RESET_PC+4`, misaligned=0.

**Latency and throughput**
- First req is asserted 1 cycle after reset release.
- With a same-cycle-ack memory, throughput is 1 instruction/cycle.
- Fetch-to-output latency is 0 cycles (combinational from rdata). The FD register captures the instruction on the same edge.
- A redirect takes effect on the next edge: the target request is issued the following cycle, or after the drain ack.

**Reset mid-transaction**
- Reset drops req asynchronously.
- The memory must tolerate an abandoned request. Any ack arriving after reset is ignored because the FSM is in IDLE.

**Wrap-around**
- PC+4 wraps from `32'hFFFF_FFFC` to `32'h0000_0000`. No flag is raised.

## Configuration
- Macro: `RISCV_FETCH_MISALIGN_EN`.
- **Defined:**
  - A redirect whose target has bits [1:0] != 0 loads the target into `r_pc` and enters ERR instead of FETCH/DRAIN. From DRAIN, ERR is entered only after the pending ack.
  - In ERR: req=0, valid=0, `o_fetch_misaligned`=1. ERR is left only on an aligned redirect (to FETCH) or on reset.
- **Undefined:**
  - The redirect target has bits [1:0] forced to 0.
  - ERR does not exist and `o_fetch_misaligned` is tied to 0. The port is present in both builds.

## Test plan
- **Reset:** reset released, memory acks same-cycle with rdata = addr -> first req cycle 1 at `0x0`, then valid outputs pc 0,4,8,… on consecutive cycles.
- **Stall:** at pc `0x8`, stall=1 for 3 cycles -> req=0 for those cycles, instr held at `0x8`'s word, next req at `0xC` after stall drops, no duplicate.
- **Redirect during pending request:** memory acks 3 cycles after req at pc `0x10`, redirect to `0x100` in req cycle 1 -> req stays at `0x10` until ack, that data is discarded, next req at `0x100`.
- **Redirect and stall together:** redirect to `0x40` while in HOLD with stall=1 -> HOLD is exited, next fetch address is `0x40`, valid=0 in the redirect cycle.
- **Wrap-around:** redirect to `0xFFFF_FFFC` -> pcplus4=`0x0`, next fetch at `0x0`.
- **Misaligned redirect:** redirect to `0x102` -> with macro: misaligned=1, req=0 until aligned redirect to `0x200`. Without macro: fetch at `0x100`.
